// File: rtl/tmds_deserializer.sv
// One-channel TMDS receiver: DDR bit capture, control-token word alignment,
// lock supervision and TMDS 8b/10b decode, all on serclk.
//
// state  | meaning
// -------+------------------------------------------------------------
// HUNT   | scan both bit phases every cycle for a control token
// VERIFY | alignment chosen; counting consecutive tokens at boundaries
// LOCKED | alignment trusted; one decoded word per 5 cycles
module tmds_deserializer #(
  parameter int LOCK_TOKENS   = 4,
  parameter int TIMEOUT_WORDS = 4096
) (
  input  logic       serclk,
  input  logic       rst_n,
  input  logic       rising,
  input  logic       falling,
  input  logic       realign,
  output logic [9:0] word,
  output logic [7:0] data,
  output logic [1:0] c,
  output logic       de,
  output logic       valid,
  output logic       locked
);

  typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCKED} state_t;

  localparam logic [3:0]  LOCK_N = 4'(LOCK_TOKENS);
  localparam logic [15:0] TO_N   = 16'(TIMEOUT_WORDS);

  state_t      state, state_nx;
  // Bit 0 of the nominal 12-bit history is never part of a candidate, so it is not kept.
  logic [11:1] sr;
  logic [2:0]  phase, phase_nx;
  logic        sel_b, sel_b_nx;
  logic [3:0]  tok_cnt, tok_cnt_nx, tok_cnt_inc;
  logic [15:0] to_cnt, to_cnt_nx, to_cnt_inc;
  logic [9:0]  word_nx, cand_a, cand_b, cand_sel;
  logic [7:0]  data_nx;
  logic [1:0]  c_nx;
  logic        de_nx, valid_nx, boundary;

  function automatic logic is_token(input logic [9:0] q);
    case (q)
      10'b1101010100, 10'b0010101011,
      10'b0101010100, 10'b1010101011: is_token = 1'b1;
      default:                        is_token = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] token_code(input logic [9:0] q);
    case (q)
      10'b0010101011: token_code = 2'b01;
      10'b0101010100: token_code = 2'b10;
      10'b1010101011: token_code = 2'b11;
      default:        token_code = 2'b00;
    endcase
  endfunction

  function automatic logic [7:0] decode_byte(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] r;
    d    = q[9] ? ~q[7:0] : q[7:0];
    r    = '0;
    r[0] = d[0];
    for (int i = 1; i < 8; i++)
      r[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return r;
  endfunction

  assign cand_a      = sr[11:2];
  assign cand_b      = sr[10:1];
  assign cand_sel    = sel_b ? cand_b : cand_a;
  assign boundary    = (phase == 3'd4);
  assign tok_cnt_inc = (tok_cnt == 4'hF) ? tok_cnt : tok_cnt + 4'd1;
  assign to_cnt_inc  = (to_cnt == 16'hFFFF) ? to_cnt : to_cnt + 16'd1;
  assign locked      = (state == S_LOCKED);

  always_comb begin
    state_nx   = state;
    phase_nx   = boundary ? 3'd0 : phase + 3'd1;
    sel_b_nx   = sel_b;
    tok_cnt_nx = tok_cnt;
    to_cnt_nx  = to_cnt;
    word_nx    = word;
    data_nx    = data;
    c_nx       = c;
    de_nx      = de;
    valid_nx   = 1'b0;
    if (realign) begin
      state_nx   = S_HUNT;
      phase_nx   = 3'd0;
      tok_cnt_nx = '0;
      to_cnt_nx  = '0;
    end else begin
      case (state)
        S_HUNT: begin
          if (is_token(cand_a) || is_token(cand_b)) begin
            sel_b_nx   = !is_token(cand_a);
            tok_cnt_nx = 4'd1;
            to_cnt_nx  = '0;
            phase_nx   = 3'd0;
            state_nx   = (LOCK_TOKENS <= 1) ? S_LOCKED : S_VERIFY;
          end
        end
        S_VERIFY: begin
          if (boundary) begin
            if (is_token(cand_sel)) begin
              tok_cnt_nx = tok_cnt_inc;
              if (tok_cnt_inc >= LOCK_N) begin
                state_nx  = S_LOCKED;
                to_cnt_nx = '0;
              end
            end else begin
              state_nx   = S_HUNT;
              tok_cnt_nx = '0;
            end
          end
        end
        S_LOCKED: begin
          if (boundary) begin
            valid_nx = 1'b1;
            word_nx  = cand_sel;
            if (is_token(cand_sel)) begin
              de_nx     = 1'b0;
              c_nx      = token_code(cand_sel);
              data_nx   = '0;
              to_cnt_nx = '0;
            end else begin
              de_nx     = 1'b1;
              data_nx   = decode_byte(cand_sel);
              to_cnt_nx = to_cnt_inc;
              // The word that exhausts the timeout is still emitted.
              if (to_cnt_inc >= TO_N) begin
                state_nx   = S_HUNT;
                to_cnt_nx  = '0;
                tok_cnt_nx = '0;
              end
            end
          end
        end
        default: state_nx = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge serclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_HUNT;
      sr      <= '0;
      phase   <= '0;
      sel_b   <= 1'b0;
      tok_cnt <= '0;
      to_cnt  <= '0;
      word    <= '0;
      data    <= '0;
      c       <= '0;
      de      <= 1'b0;
      valid   <= 1'b0;
    end else begin
      sr      <= {falling, rising, sr[11:3]};
      state   <= state_nx;
      phase   <= phase_nx;
      sel_b   <= sel_b_nx;
      tok_cnt <= tok_cnt_nx;
      to_cnt  <= to_cnt_nx;
      word    <= word_nx;
      data    <= data_nx;
      c       <= c_nx;
      de      <= de_nx;
      valid   <= valid_nx;
    end
  end

endmodule
